// File: rtl/game_sequencer.sv
// Game-flow controller: sequences IDLE/PLAY/HIT/OVER, gates object motion per frame,
// and keeps lives, a BCD survival score and a hit counter for the display.
module game_sequencer #(
   parameter int unsigned NUM_LIVES    = 3,
   parameter int unsigned FLASH_FRAMES = 30,
   parameter int unsigned SCORE_FRAMES = 60
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic        start,
   input  logic        frame_tick,
   input  logic        hit,
   output logic        move_en,
   output logic        obj_rst,
   output logic        flash,
   output logic [1:0]  state,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic [3:0]  hit_count
);

   localparam int unsigned CNT_W = 8;
   localparam logic [1:0]       LIVES_INIT = 2'(NUM_LIVES);
   localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_FRAMES);
   localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_FRAMES - 1);
   localparam logic [15:0]      SCORE_MAX  = 16'h9999;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      HIT  = 2'b10,
      OVER = 2'b11
   } state_t;

   state_t           cur_state;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] flash_cnt;
   logic             start_d;
   logic             hit_d;
   logic             start_rise;
   logic             hit_rise;

   assign start_rise = start & ~start_d;
   assign hit_rise   = hit & ~hit_d;
   assign state      = cur_state;

   // BCD increment with per-digit carry, saturating at 9999
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v != SCORE_MAX) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         cur_state <= IDLE;
         lives     <= LIVES_INIT;
         score     <= 16'h0000;
         hit_count <= 4'd0;
         move_en   <= 1'b0;
         obj_rst   <= 1'b0;
         flash     <= 1'b0;
         frame_cnt <= '0;
         flash_cnt <= '0;
         start_d   <= 1'b0;
         hit_d     <= 1'b0;
      end else begin
         start_d <= start;
         hit_d   <= hit;
         move_en <= 1'b0;
         obj_rst <= 1'b0;
         case (cur_state)
            IDLE, OVER: begin
               flash <= 1'b0;
               if (start_rise) begin
                  cur_state <= PLAY;
                  obj_rst   <= 1'b1;
                  lives     <= LIVES_INIT;
                  score     <= 16'h0000;
                  frame_cnt <= '0;
               end
            end
            PLAY: begin
               // a hit takes priority over a coincident frame tick
               if (hit_rise) begin
                  cur_state <= HIT;
                  lives     <= lives - 2'd1;
                  hit_count <= hit_count + 4'd1;
                  flash_cnt <= FLASH_INIT;
                  flash     <= 1'b1;
               end else if (frame_tick) begin
                  move_en <= 1'b1;
                  if (frame_cnt == SCORE_LAST) begin
                     frame_cnt <= '0;
                     score     <= bcd_inc(score);
                  end else begin
                     frame_cnt <= frame_cnt + CNT_W'(1);
                  end
               end
            end
            HIT: begin
               if (frame_tick) begin
                  if (flash_cnt == CNT_W'(1)) begin
                     flash <= 1'b0;
                     if (lives == 2'd0) begin
                        cur_state <= OVER;
                     end else begin
                        cur_state <= PLAY;
                        obj_rst   <= 1'b1;
                        frame_cnt <= '0;
                     end
                  end else begin
                     flash_cnt <= flash_cnt - CNT_W'(1);
                  end
               end
            end
            default: cur_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: vector table, directed game sequences, random play against
// an integer-arithmetic reference model, and a long score run on a fast-scoring instance.
module tb_game_sequencer;

   localparam int unsigned NL = 3;
   localparam int unsigned FF = 2;
   localparam int unsigned SF = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, s, f, h;
   logic m, o, fl;
   logic [1:0] st, lv;
   logic [15:0] sc;
   logic [3:0] hc;

   logic rst2, s2, f2, h2;
   logic m2, o2, fl2;
   logic [1:0] st2, lv2;
   logic [15:0] sc2;
   logic [3:0] hc2;

   game_sequencer #(.NUM_LIVES(NL), .FLASH_FRAMES(FF), .SCORE_FRAMES(SF)) dut (
      .ClkPort(clk), .Reset(rst), .start(s), .frame_tick(f), .hit(h),
      .move_en(m), .obj_rst(o), .flash(fl), .state(st), .lives(lv),
      .score(sc), .hit_count(hc));

   game_sequencer #(.NUM_LIVES(NL), .FLASH_FRAMES(FF), .SCORE_FRAMES(1)) dut_fast (
      .ClkPort(clk), .Reset(rst2), .start(s2), .frame_tick(f2), .hit(h2),
      .move_en(m2), .obj_rst(o2), .flash(fl2), .state(st2), .lives(lv2),
      .score(sc2), .hit_count(hc2));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: game rules in plain integers (score kept as a decimal count)
   int ms, ml, msc, mhc, mfc, mflc;
   bit mps, mph, mmv, mor;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic model(input bit r_i, input bit s_i, input bit f_i, input bit h_i);
      bit sr, hr;
      if (r_i) begin
         ms = 0; ml = NL; msc = 0; mhc = 0; mfc = 0; mflc = 0;
         mps = 0; mph = 0; mmv = 0; mor = 0;
         return;
      end
      sr = s_i && !mps;
      hr = h_i && !mph;
      mmv = 0;
      mor = 0;
      if (ms == 0 || ms == 3) begin
         if (sr) begin
            ms = 1; mor = 1; ml = NL; msc = 0; mfc = 0;
         end
      end else if (ms == 1) begin
         if (hr) begin
            ms = 2; ml = ml - 1; mhc = (mhc + 1) % 16; mflc = FF;
         end else if (f_i) begin
            mmv = 1;
            mfc = mfc + 1;
            if (mfc == SF) begin
               mfc = 0;
               msc = (msc + 1 > 9999) ? 9999 : msc + 1;
            end
         end
      end else if (f_i) begin
         if (mflc == 1) begin
            if (ml == 0) ms = 3;
            else begin ms = 1; mor = 1; mfc = 0; end
         end else mflc = mflc - 1;
      end
      mps = s_i;
      mph = h_i;
   endtask

   task automatic step(input logic r_i, input logic s_i, input logic f_i, input logic h_i);
      rst = r_i; s = s_i; f = f_i; h = h_i;
      @(posedge clk);
      model(r_i, s_i, f_i, h_i);
      #1;
      chk("m_state", 16'(st), 16'(ms));
      chk("m_lives", 16'(lv), 16'(ml));
      chk("m_score", sc, to_bcd(msc));
      chk("m_hits", 16'(hc), 16'(mhc));
      chk("m_move_en", 16'(m), 16'(mmv));
      chk("m_obj_rst", 16'(o), 16'(mor));
      chk("m_flash", 16'(fl), 16'(ms == 2));
   endtask

   typedef struct {
      logic r, s, f, h;
      logic [1:0] st, lv;
      logic [15:0] sc;
      logic [3:0] hc;
      logic mv, orr, fl;
   } vec_t;

   vec_t tbl[20];

   initial begin
      rst = 1'b1; s = 1'b0; f = 1'b0; h = 1'b0;
      rst2 = 1'b1; s2 = 1'b0; f2 = 1'b0; h2 = 1'b0;
      model(1'b1, 1'b0, 1'b0, 1'b0);

      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 2'd0,2'd3,16'h0000,4'd0, 1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b1,1'b0,1'b0, 2'd1,2'd3,16'h0000,4'd0, 1'b0,1'b1,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b0,1'b0, 2'd1,2'd3,16'h0000,4'd0, 1'b0,1'b0,1'b0};
      tbl[3]  = tbl[2];
      tbl[4]  = tbl[2];
      tbl[5]  = tbl[2];
      tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 2'd1,2'd3,16'h0000,4'd0, 1'b1,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0, 2'd1,2'd3,16'h0000,4'd0, 1'b0,1'b0,1'b0};
      tbl[8]  = tbl[6];
      tbl[9]  = tbl[6];
      tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 2'd1,2'd3,16'h0001,4'd0, 1'b1,1'b0,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b1, 2'd2,2'd2,16'h0001,4'd1, 1'b0,1'b0,1'b1};
      tbl[12] = '{1'b0,1'b0,1'b0,1'b1, 2'd2,2'd2,16'h0001,4'd1, 1'b0,1'b0,1'b1};
      tbl[13] = '{1'b0,1'b0,1'b1,1'b0, 2'd2,2'd2,16'h0001,4'd1, 1'b0,1'b0,1'b1};
      tbl[14] = '{1'b0,1'b0,1'b1,1'b0, 2'd1,2'd2,16'h0001,4'd1, 1'b0,1'b1,1'b0};
      tbl[15] = '{1'b0,1'b0,1'b1,1'b0, 2'd1,2'd2,16'h0001,4'd1, 1'b1,1'b0,1'b0};
      tbl[16] = '{1'b0,1'b0,1'b0,1'b1, 2'd2,2'd1,16'h0001,4'd2, 1'b0,1'b0,1'b1};
      tbl[17] = '{1'b1,1'b0,1'b0,1'b0, 2'd0,2'd3,16'h0000,4'd0, 1'b0,1'b0,1'b0};
      tbl[18] = '{1'b0,1'b0,1'b1,1'b0, 2'd0,2'd3,16'h0000,4'd0, 1'b0,1'b0,1'b0};
      tbl[19] = '{1'b0,1'b1,1'b1,1'b0, 2'd1,2'd3,16'h0000,4'd0, 1'b0,1'b1,1'b0};

      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].h);
         chk($sformatf("tbl%0d_state", i), 16'(st), 16'(tbl[i].st));
         chk($sformatf("tbl%0d_lives", i), 16'(lv), 16'(tbl[i].lv));
         chk($sformatf("tbl%0d_score", i), sc, tbl[i].sc);
         chk($sformatf("tbl%0d_hits", i), 16'(hc), 16'(tbl[i].hc));
         chk($sformatf("tbl%0d_pulses", i), 16'({m, o, fl}), 16'({tbl[i].mv, tbl[i].orr, tbl[i].fl}));
      end

      // nine spaced frames: a move pulse per tick, two score increments
      for (int k = 0; k < 9; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("t2_move_hi", 16'(m), 16'd1);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("t2_move_lo", 16'(m), 16'd0);
      end
      chk("t2_score", sc, 16'h0002);

      // three hits exhaust the lives and end the game
      for (int j = 0; j < 3; j++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("t4_flash", 16'(fl), 16'd1);
         step(1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("t4_over", 16'(st), 16'd3);
      chk("t4_lives0", 16'(lv), 16'd0);
      chk("t4_flash0", 16'(fl), 16'd0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("t4_no_move", 16'(m), 16'd0);
         chk("t4_score_hold", sc, 16'h0002);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_restart_state", 16'(st), 16'd1);
      chk("t4_restart_lives", 16'(lv), 16'd3);
      chk("t4_restart_score", sc, 16'h0000);
      chk("t4_keep_hits", 16'(hc), 16'd3);
      chk("t4_restart_objrst", 16'(o), 16'd1);

      // reset in the middle of a flash
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_flash_on", 16'(fl), 16'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6_state", 16'(st), 16'd0);
      chk("t6_flash", 16'(fl), 16'd0);
      chk("t6_hits", 16'(hc), 16'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("t6_quiet", 16'({m, o}), 16'd0);
      end

      // random play against the model
      begin
         logic rs, rf, rh, rr;
         rs = 1'b0; rh = 1'b0;
         for (int k = 0; k < 4000; k++) begin
            rr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            if ($urandom_range(0, 5) == 0) rh = ~rh;
            rf = ($urandom_range(0, 2) == 0);
            step(rr, rs, rf, rh);
         end
      end

      // long run on the fast-scoring instance: carry and saturation
      @(posedge clk); #1;
      rst2 = 1'b0; s2 = 1'b1;
      @(posedge clk); #1;
      chk("fast_start", 16'({st2, o2}), 16'({2'd1, 1'b1}));
      f2 = 1'b1;
      for (int k = 1; k <= 10003; k++) begin
         @(posedge clk); #1;
         if (k == 99)    chk("fast_0099", sc2, 16'h0099);
         if (k == 100)   chk("fast_0100", sc2, 16'h0100);
         if (k == 1000)  chk("fast_1000", sc2, 16'h1000);
         if (k == 9999)  chk("fast_9999", sc2, 16'h9999);
         if (k == 10003) chk("fast_sat", sc2, 16'h9999);
      end
      chk("fast_move", 16'(m2), 16'd1);
      chk("fast_misc", 16'({fl2, lv2, hc2}), 16'({1'b0, 2'd3, 4'd0}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game-flow controller between the VGA timing/collision logic and the per-object block controllers.
- Sequences play (IDLE/PLAY/HIT/OVER) and gates object motion to one step per frame.
- Re-seeds object positions after a hit; drives the collision flash override.
- Maintains lives, a BCD survival score and a hit counter for the seven-segment display.

Parameters:
NUM_LIVES, 3, lives loaded on game start (1..3)
FLASH_FRAMES, 30, frames spent in HIT flashing (1..255)
SCORE_FRAMES, 60, PLAY frames per score increment (1..255)

Ports:
ClkPort  input  1  system clock (100 MHz)
Reset  input  1  synchronous, active-high reset
start  input  1  start button level (already synchronized); rising edge detected internally
frame_tick  input  1  one-cycle pulse per frame (start of vertical blank)
hit  input  1  level; OR of all player/object collision comparators
move_en  output  1  one-cycle pulse; object controllers advance one step
obj_rst  output  1  one-cycle pulse; object controllers reload start positions
flash  output  1  high while the collision colour override is applied
state  output  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER
lives  output  2  remaining lives
score  output  16  4-digit BCD score, digit 0 = [3:0]
hit_count  output  4  total hits, wraps 15->0

Behaviour:
- Synchronous reset and interface:
  - Everything is synchronous to ClkPort; Reset is sampled on the clock edge only.
  - Reset values: state=IDLE, lives=NUM_LIVES, score=0000, hit_count=0, move_en=0, obj_rst=0, flash=0; internal frame/flash counters=0, edge registers=0.
  - Reset asserted mid-game aborts immediately: reset values appear on the edge where Reset is sampled high.
- Edge detection and latency:
  - start_d and hit_d register the previous input value every cycle, in all states.
  - start_rise = start & ~start_d; hit_rise = hit & ~hit_d.
  - All outputs are registered. A qualifying event in cycle N produces its state change or pulse at edge N+1.
- IDLE:
  - flash=0, move_en=0.
  - On start_rise: ->PLAY; pulse obj_rst; lives=NUM_LIVES; score=0; frame counter=0. hit_count is not cleared.
- PLAY:
  - On frame_tick with no hit_rise:
    - pulse move_en.
    - Frame counter increments. At SCORE_FRAMES-1 it wraps to 0 and score increments in BCD, with per-digit carry at 9.
    - Score saturates at 9999.
  - On hit_rise:
    - ->HIT; lives decrements; hit_count increments; flash counter=FLASH_FRAMES.
    - If hit_rise and frame_tick occur in the same cycle, the hit wins: no move_en and no score/frame-counter update that frame.
- HIT:
  - flash=1, move_en=0; hit_rise and start_rise are ignored.
  - On frame_tick the flash counter decrements. When frame_tick arrives with the counter at 1:
    - lives==0: ->OVER.
    - otherwise: ->PLAY with an obj_rst pulse; frame counter=0.
  - flash drops in the same edge as the state change.
- OVER:
  - flash=0, move_en=0; score, lives (0) and hit_count are held.
  - On start_rise: same actions as start from IDLE.
- General rules:
  - start_rise in PLAY/HIT has no effect.
  - A hit held high across HIT->PLAY is not re-counted, since it is edge-detected.
  - lives never underflows: the HIT path reaches OVER at 0.
  - obj_rst and move_en are never high in the same cycle.
  - move_en never pulses outside PLAY.

Test Plan:
(Benches run with NUM_LIVES=3, FLASH_FRAMES=2, SCORE_FRAMES=4.)
1. Reset, then hold start=1 for 5 cycles -> one obj_rst pulse; state=01; lives=3, score=0000. start held high gives no further effect.
2. In PLAY, 9 frame_ticks and no hit -> 9 move_en pulses, each 1 cycle after its tick; score=0002.
3. hit rises in the same cycle as frame_tick -> no move_en. Next edge: state=10, lives=2, hit_count=1, flash=1. After 2 frame_ticks -> state=01, flash=0, one obj_rst pulse.
4. Three separate hits, each followed by 2 frames -> after the third: state=11, lives=0, flash=0. Further frame_ticks give no move_en and score is unchanged. Then start_rise -> PLAY, lives=3, score=0000, hit_count=3.
5. Preload a score of 9999 (force, or a long run) plus 4 more frames -> score stays 9999. Separately, 0099 + 4 frames -> 0100.
6. Assert Reset for 1 cycle while in HIT with flash=1 -> next edge: state=00, flash=0, lives=3, score=0000, hit_count=0. No move_en or obj_rst pulses follow without start.
